// File: rtl/snd_n163_arb.sv
// N163-style wave RAM arbiter: CPU address/data ports with auto-increment and prefetch,
// a two-deep posted write queue, and an engine port with starvation-bounded access.
module snd_n163_arb #(
    parameter int DATA_W = 8
) (
    input  logic              m2,
    input  logic              map_rst,
    input  logic [15:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    input  logic              cpu_rw,
    output logic [DATA_W-1:0] cpu_dout,
    input  logic              eng_req,
    input  logic              eng_we,
    input  logic [6:0]        eng_addr,
    input  logic [DATA_W-1:0] eng_wdat,
    output logic              eng_gnt,
    output logic [DATA_W-1:0] eng_rdat,
    output logic              eng_rvalid,
    output logic [6:0]        ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdat,
    input  logic [DATA_W-1:0] ram_rdat,
    output logic [6:0]        addr_reg,
    output logic              auto_inc
);

    typedef enum logic [1:0] {SLOT_IDLE, SLOT_WR, SLOT_PF, SLOT_ENG} slot_t;

    slot_t             slot;
    logic              data_sel, addr_sel, addr_wr, data_wr, data_acc;
    logic              push, pop;
    logic [1:0]        fifo_cnt;
    logic [6:0]        fifo_addr [2];
    logic [DATA_W-1:0] fifo_dat [2];
    logic              wr_idx;
    logic [1:0]        starve_cnt;
    logic              pf_pend;
    logic [DATA_W-1:0] pf_latch;
    logic              pf_vld_p1, eng_vld_p1;
    logic [6:0]        last_addr;
    logic [DATA_W-1:0] last_wdat;
    logic              unused_addr_bits;

    assign data_sel = (cpu_addr[15:11] == 5'b01001);
    assign addr_sel = (cpu_addr[15:11] == 5'b11111);
    assign addr_wr  = !map_rst && addr_sel && !cpu_rw;
    assign data_wr  = !map_rst && data_sel && !cpu_rw;
    assign data_acc = !map_rst && data_sel;
    assign unused_addr_bits = ^cpu_addr[10:0];

    assign push   = data_wr;
    assign pop    = (slot == SLOT_WR);
    assign wr_idx = fifo_cnt[0] ^ pop;

    // A full queue must drain first so a same-cycle push can never overflow it
    always_comb begin
        slot = SLOT_IDLE;
        if (map_rst)
            slot = SLOT_IDLE;
        else if (fifo_cnt == 2'd2)
            slot = SLOT_WR;
        else if (eng_req && starve_cnt == 2'd3)
            slot = SLOT_ENG;
        else if (fifo_cnt != 2'd0)
            slot = SLOT_WR;
        else if (pf_pend)
            slot = SLOT_PF;
        else if (eng_req)
            slot = SLOT_ENG;
    end

    always_comb begin
        ram_addr = last_addr;
        ram_wdat = last_wdat;
        ram_we   = 1'b0;
        eng_gnt  = 1'b0;
        case (slot)
            SLOT_WR: begin
                ram_addr = fifo_addr[0];
                ram_wdat = fifo_dat[0];
                ram_we   = 1'b1;
            end
            SLOT_PF:  ram_addr = addr_reg;
            SLOT_ENG: begin
                ram_addr = eng_addr;
                ram_wdat = eng_wdat;
                ram_we   = eng_we;
                eng_gnt  = 1'b1;
            end
            default: ;
        endcase
        if (map_rst) begin
            ram_addr = '0;
            ram_wdat = '0;
        end
    end

    assign cpu_dout   = map_rst ? '0 : pf_latch;
    assign eng_rvalid = eng_vld_p1 && !map_rst;
    assign eng_rdat   = ram_rdat;

    always_ff @(negedge m2) begin
        if (map_rst) begin
            addr_reg   <= '0;
            auto_inc   <= 1'b0;
            fifo_cnt   <= 2'd0;
            starve_cnt <= 2'd0;
            pf_pend    <= 1'b1;
            pf_latch   <= '0;
            pf_vld_p1  <= 1'b0;
            eng_vld_p1 <= 1'b0;
            last_addr  <= '0;
            last_wdat  <= '0;
        end else begin
            if (addr_wr) begin
                addr_reg <= cpu_data[6:0];
                auto_inc <= cpu_data[7];
            end else if (data_acc && auto_inc) begin
                addr_reg <= addr_reg + 7'd1;
            end

            // A pointer move or access during a PF slot makes that fetch stale
            if (addr_wr || data_acc)
                pf_pend <= 1'b1;
            else if (slot == SLOT_PF)
                pf_pend <= 1'b0;

            if (!eng_req || eng_gnt)
                starve_cnt <= 2'd0;
            else if (starve_cnt != 2'd3)
                starve_cnt <= starve_cnt + 2'd1;

            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase

            if (slot != SLOT_IDLE) begin
                last_addr <= ram_addr;
                last_wdat <= ram_wdat;
            end

            // Stage p1: RAM read data returns one cycle after its slot
            pf_vld_p1  <= (slot == SLOT_PF);
            eng_vld_p1 <= eng_gnt && !eng_we;
            if (pf_vld_p1)
                pf_latch <= ram_rdat;
        end
    end

    always_ff @(negedge m2) begin
        if (pop) begin
            fifo_addr[0] <= fifo_addr[1];
            fifo_dat[0]  <= fifo_dat[1];
        end
        if (push) begin
            fifo_addr[wr_idx] <= addr_reg;
            fifo_dat[wr_idx]  <= cpu_data;
        end
    end

endmodule

// File: tb/tb_snd_n163_arb.sv
// Directed bench for snd_n163_arb: per-cycle vector table plus a reset-with-queued-writes sequence.
module tb_snd_n163_arb;

    logic        m2;
    logic        map_rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        cpu_rw;
    logic [7:0]  cpu_dout;
    logic        eng_req, eng_we;
    logic [6:0]  eng_addr;
    logic [7:0]  eng_wdat;
    logic        eng_gnt;
    logic [7:0]  eng_rdat;
    logic        eng_rvalid;
    logic [6:0]  ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdat;
    logic [7:0]  ram_rdat;
    logic [6:0]  addr_reg;
    logic        auto_inc;

    int n_chk  = 0;
    int n_pass = 0;

    snd_n163_arb #(.DATA_W(8)) dut (
        .m2(m2), .map_rst(map_rst), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .cpu_rw(cpu_rw), .cpu_dout(cpu_dout), .eng_req(eng_req), .eng_we(eng_we),
        .eng_addr(eng_addr), .eng_wdat(eng_wdat), .eng_gnt(eng_gnt), .eng_rdat(eng_rdat),
        .eng_rvalid(eng_rvalid), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdat(ram_wdat),
        .ram_rdat(ram_rdat), .addr_reg(addr_reg), .auto_inc(auto_inc)
    );

    initial m2 = 1'b1;
    always #5 m2 = ~m2;

    // External wave RAM: synchronous, one-cycle read latency, preloaded with i+0x80
    logic [7:0] mem [128];
    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'(i + 8'h80);
        ram_rdat = 8'h00;
    end
    always @(negedge m2) begin
        if (ram_we) mem[ram_addr] <= ram_wdat;
        ram_rdat <= mem[ram_addr];
    end

    typedef struct {
        logic        rst;
        logic [15:0] ca;
        logic [7:0]  cd;
        logic        rw;
        logic        er;
        logic        ew;
        logic [6:0]  ea;
        logic [7:0]  ed;
        logic        xwe;
        logic [6:0]  xaddr;
        logic [7:0]  xwdat;
        logic        xgnt;
        logic        xrv;
        logic [7:0]  xrdat;
        logic [6:0]  xar;
        logic        xai;
        logic [7:0]  xdout;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t r(input logic rst, input logic [15:0] ca, input logic [7:0] cd,
                               input logic rw, input logic er, input logic ew,
                               input logic [6:0] ea, input logic [7:0] ed,
                               input logic xwe, input logic [6:0] xaddr, input logic [7:0] xwdat,
                               input logic xgnt, input logic xrv, input logic [7:0] xrdat,
                               input logic [6:0] xar, input logic xai, input logic [7:0] xdout);
        vec_t v;
        v.rst = rst; v.ca = ca; v.cd = cd; v.rw = rw; v.er = er; v.ew = ew; v.ea = ea; v.ed = ed;
        v.xwe = xwe; v.xaddr = xaddr; v.xwdat = xwdat; v.xgnt = xgnt; v.xrv = xrv;
        v.xrdat = xrdat; v.xar = xar; v.xai = xai; v.xdout = xdout;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0d: got %h, expected %h", nm, idx, act, exp);
    endtask

    task automatic drive(input logic rst, input logic [15:0] ca, input logic [7:0] cd, input logic rw,
                         input logic er, input logic ew, input logic [6:0] ea, input logic [7:0] ed);
        map_rst = rst; cpu_addr = ca; cpu_data = cd; cpu_rw = rw;
        eng_req = er; eng_we = ew; eng_addr = ea; eng_wdat = ed;
    endtask

    task automatic next_cycle();
        @(negedge m2);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // rst, addr, data, rw, er, ew, ea, ed | we, raddr, wdat, gnt, rv, rdat, addr_reg, ai, dout
        tbl.push_back(r(1, 16'h0000, 8'h00, 1, 0, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 0, 0, 8'h00, 7'h00, 0, 8'h00));
        tbl.push_back(r(0, 16'h0000, 8'h00, 1, 0, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 0, 0, 8'h00, 7'h00, 0, 8'h00));
        tbl.push_back(r(0, 16'hF800, 8'h85, 0, 0, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 0, 0, 8'h00, 7'h00, 0, 8'h00));
        tbl.push_back(r(0, 16'h4800, 8'h3C, 0, 0, 0, 7'h00, 8'h00, 0, 7'h05, 8'h00, 0, 0, 8'h00, 7'h05, 1, 8'h80));
        tbl.push_back(r(0, 16'h4800, 8'h5A, 0, 0, 0, 7'h00, 8'h00, 1, 7'h05, 8'h3C, 0, 0, 8'h00, 7'h06, 1, 8'h80));
        tbl.push_back(r(0, 16'h0000, 8'h00, 1, 0, 0, 7'h00, 8'h00, 1, 7'h06, 8'h5A, 0, 0, 8'h00, 7'h07, 1, 8'h85));
        tbl.push_back(r(0, 16'h0000, 8'h00, 1, 0, 0, 7'h00, 8'h00, 0, 7'h07, 8'h00, 0, 0, 8'h00, 7'h07, 1, 8'h85));
        tbl.push_back(r(0, 16'h0000, 8'h00, 1, 0, 0, 7'h00, 8'h00, 0, 7'h07, 8'h00, 0, 0, 8'h00, 7'h07, 1, 8'h85));
        tbl.push_back(r(0, 16'h0000, 8'h00, 1, 0, 0, 7'h00, 8'h00, 0, 7'h07, 8'h00, 0, 0, 8'h00, 7'h07, 1, 8'h87));
        tbl.push_back(r(0, 16'hF800, 8'hFF, 0, 0, 0, 7'h00, 8'h00, 0, 7'h07, 8'h00, 0, 0, 8'h00, 7'h07, 1, 8'h87));
        tbl.push_back(r(0, 16'h0000, 8'h00, 1, 0, 0, 7'h00, 8'h00, 0, 7'h7F, 8'h00, 0, 0, 8'h00, 7'h7F, 1, 8'h87));
        tbl.push_back(r(0, 16'h0000, 8'h00, 1, 0, 0, 7'h00, 8'h00, 0, 7'h7F, 8'h00, 0, 0, 8'h00, 7'h7F, 1, 8'h87));
        tbl.push_back(r(0, 16'h4800, 8'h00, 1, 0, 0, 7'h00, 8'h00, 0, 7'h7F, 8'h00, 0, 0, 8'h00, 7'h7F, 1, 8'hFF));
        tbl.push_back(r(0, 16'h0000, 8'h00, 1, 0, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 0, 0, 8'h00, 7'h00, 1, 8'hFF));
        tbl.push_back(r(0, 16'h0000, 8'h00, 1, 0, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 0, 0, 8'h00, 7'h00, 1, 8'hFF));
        tbl.push_back(r(0, 16'h4800, 8'h00, 1, 0, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 0, 0, 8'h00, 7'h00, 1, 8'h80));
        tbl.push_back(r(0, 16'h0000, 8'h00, 1, 0, 0, 7'h00, 8'h00, 0, 7'h01, 8'h00, 0, 0, 8'h00, 7'h01, 1, 8'h80));
        tbl.push_back(r(0, 16'h0000, 8'h00, 1, 0, 0, 7'h00, 8'h00, 0, 7'h01, 8'h00, 0, 0, 8'h00, 7'h01, 1, 8'h80));
        tbl.push_back(r(0, 16'h0000, 8'h00, 1, 1, 0, 7'h40, 8'h00, 0, 7'h40, 8'h00, 1, 0, 8'h00, 7'h01, 1, 8'h81));
        tbl.push_back(r(0, 16'h0000, 8'h00, 1, 0, 0, 7'h00, 8'h00, 0, 7'h40, 8'h00, 0, 1, 8'hC0, 7'h01, 1, 8'h81));
        tbl.push_back(r(0, 16'h0000, 8'h00, 1, 0, 0, 7'h00, 8'h00, 0, 7'h40, 8'h00, 0, 0, 8'h00, 7'h01, 1, 8'h81));
        tbl.push_back(r(0, 16'h0000, 8'h00, 1, 1, 1, 7'h41, 8'h77, 1, 7'h41, 8'h77, 1, 0, 8'h00, 7'h01, 1, 8'h81));
        tbl.push_back(r(0, 16'h0000, 8'h00, 1, 0, 0, 7'h00, 8'h00, 0, 7'h41, 8'h00, 0, 0, 8'h00, 7'h01, 1, 8'h81));
        tbl.push_back(r(0, 16'hF800, 8'h20, 0, 0, 0, 7'h00, 8'h00, 0, 7'h41, 8'h00, 0, 0, 8'h00, 7'h01, 1, 8'h81));
        tbl.push_back(r(0, 16'h4800, 8'h11, 0, 1, 0, 7'h42, 8'h00, 0, 7'h20, 8'h00, 0, 0, 8'h00, 7'h20, 0, 8'h81));
        tbl.push_back(r(0, 16'h4800, 8'h22, 0, 1, 0, 7'h42, 8'h00, 1, 7'h20, 8'h11, 0, 0, 8'h00, 7'h20, 0, 8'h81));
        tbl.push_back(r(0, 16'h4800, 8'h33, 0, 1, 0, 7'h42, 8'h00, 1, 7'h20, 8'h22, 0, 0, 8'h00, 7'h20, 0, 8'hA0));
        tbl.push_back(r(0, 16'h4800, 8'h44, 0, 1, 0, 7'h42, 8'h00, 0, 7'h42, 8'h00, 1, 0, 8'h00, 7'h20, 0, 8'hA0));
        tbl.push_back(r(0, 16'h4800, 8'h55, 0, 0, 0, 7'h00, 8'h00, 1, 7'h20, 8'h33, 0, 1, 8'hC2, 7'h20, 0, 8'hA0));
        tbl.push_back(r(0, 16'h0000, 8'h00, 1, 0, 0, 7'h00, 8'h00, 1, 7'h20, 8'h44, 0, 0, 8'h00, 7'h20, 0, 8'hA0));
        tbl.push_back(r(0, 16'h0000, 8'h00, 1, 0, 0, 7'h00, 8'h00, 1, 7'h20, 8'h55, 0, 0, 8'h00, 7'h20, 0, 8'hA0));
        tbl.push_back(r(0, 16'h0000, 8'h00, 1, 0, 0, 7'h00, 8'h00, 0, 7'h20, 8'h00, 0, 0, 8'h00, 7'h20, 0, 8'hA0));
        tbl.push_back(r(0, 16'h0000, 8'h00, 1, 0, 0, 7'h00, 8'h00, 0, 7'h20, 8'h00, 0, 0, 8'h00, 7'h20, 0, 8'hA0));
        tbl.push_back(r(0, 16'h0000, 8'h00, 1, 0, 0, 7'h00, 8'h00, 0, 7'h20, 8'h00, 0, 0, 8'h00, 7'h20, 0, 8'h55));
        tbl.push_back(r(0, 16'hF800, 8'h10, 0, 0, 0, 7'h00, 8'h00, 0, 7'h20, 8'h00, 0, 0, 8'h00, 7'h20, 0, 8'h55));
        tbl.push_back(r(0, 16'h4800, 8'h99, 0, 0, 0, 7'h00, 8'h00, 0, 7'h10, 8'h00, 0, 0, 8'h00, 7'h10, 0, 8'h55));
        tbl.push_back(r(0, 16'h0000, 8'h00, 1, 0, 0, 7'h00, 8'h00, 1, 7'h10, 8'h99, 0, 0, 8'h00, 7'h10, 0, 8'h55));
        tbl.push_back(r(0, 16'h0000, 8'h00, 1, 0, 0, 7'h00, 8'h00, 0, 7'h10, 8'h00, 0, 0, 8'h00, 7'h10, 0, 8'h90));
        tbl.push_back(r(0, 16'h0000, 8'h00, 1, 0, 0, 7'h00, 8'h00, 0, 7'h10, 8'h00, 0, 0, 8'h00, 7'h10, 0, 8'h90));
        tbl.push_back(r(0, 16'h4800, 8'h00, 1, 0, 0, 7'h00, 8'h00, 0, 7'h10, 8'h00, 0, 0, 8'h00, 7'h10, 0, 8'h99));
        tbl.push_back(r(0, 16'h0000, 8'h00, 1, 0, 0, 7'h00, 8'h00, 0, 7'h10, 8'h00, 0, 0, 8'h00, 7'h10, 0, 8'h99));

        drive(1, 16'h0000, 8'h00, 1, 0, 0, 7'h00, 8'h00);
        repeat (2) next_cycle();

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].ca, tbl[i].cd, tbl[i].rw, tbl[i].er, tbl[i].ew, tbl[i].ea, tbl[i].ed);
            @(posedge m2);
            chk("ram_we", i, 16'(ram_we), 16'(tbl[i].xwe));
            chk("ram_addr", i, 16'(ram_addr), 16'(tbl[i].xaddr));
            if (tbl[i].xwe) chk("ram_wdat", i, 16'(ram_wdat), 16'(tbl[i].xwdat));
            chk("eng_gnt", i, 16'(eng_gnt), 16'(tbl[i].xgnt));
            chk("eng_rvalid", i, 16'(eng_rvalid), 16'(tbl[i].xrv));
            if (tbl[i].xrv) chk("eng_rdat", i, 16'(eng_rdat), 16'(tbl[i].xrdat));
            chk("addr_reg", i, 16'(addr_reg), 16'(tbl[i].xar));
            chk("auto_inc", i, 16'(auto_inc), 16'(tbl[i].xai));
            chk("cpu_dout", i, 16'(cpu_dout), 16'(tbl[i].xdout));
            next_cycle();
        end

        // Starve the engine behind prefetches, queue two writes, then reset
        drive(0, 16'hF800, 8'h30, 0, 0, 0, 7'h00, 8'h00);
        @(posedge m2); chk("b0_ram_addr", 100, 16'(ram_addr), 16'h10); next_cycle();
        drive(0, 16'hF800, 8'h30, 0, 1, 0, 7'h50, 8'h00);
        @(posedge m2); chk("b1_pf_addr", 101, 16'(ram_addr), 16'h30); chk("b1_gnt", 101, 16'(eng_gnt), 16'h0); next_cycle();
        @(posedge m2); chk("b2_pf_addr", 102, 16'(ram_addr), 16'h30); chk("b2_gnt", 102, 16'(eng_gnt), 16'h0); next_cycle();
        drive(0, 16'h4800, 8'hAA, 0, 1, 0, 7'h50, 8'h00);
        @(posedge m2); chk("b3_pf_addr", 103, 16'(ram_addr), 16'h30); chk("b3_gnt", 103, 16'(eng_gnt), 16'h0); next_cycle();
        drive(0, 16'h4800, 8'hBB, 0, 1, 0, 7'h50, 8'h00);
        @(posedge m2); chk("b4_starve_gnt", 104, 16'(eng_gnt), 16'h1); chk("b4_ram_addr", 104, 16'(ram_addr), 16'h50);
        chk("b4_ram_we", 104, 16'(ram_we), 16'h0); next_cycle();
        drive(1, 16'hF800, 8'h8F, 0, 0, 0, 7'h00, 8'h00);
        @(posedge m2);
        chk("rst_gnt", 105, 16'(eng_gnt), 16'h0); chk("rst_rvalid", 105, 16'(eng_rvalid), 16'h0);
        chk("rst_ram_we", 105, 16'(ram_we), 16'h0); chk("rst_ram_addr", 105, 16'(ram_addr), 16'h0);
        chk("rst_ram_wdat", 105, 16'(ram_wdat), 16'h0); chk("rst_dout", 105, 16'(cpu_dout), 16'h0);
        next_cycle();
        drive(0, 16'h0000, 8'h00, 1, 1, 0, 7'h50, 8'h00);
        @(posedge m2);
        chk("rel_pf_addr", 106, 16'(ram_addr), 16'h0); chk("rel_ram_we", 106, 16'(ram_we), 16'h0);
        chk("rel_gnt", 106, 16'(eng_gnt), 16'h0); chk("rel_rvalid", 106, 16'(eng_rvalid), 16'h0);
        chk("rel_addr_reg", 106, 16'(addr_reg), 16'h0); chk("rel_auto_inc", 106, 16'(auto_inc), 16'h0);
        chk("rel_dout", 106, 16'(cpu_dout), 16'h0);
        next_cycle();
        @(posedge m2);
        chk("rereq_gnt", 107, 16'(eng_gnt), 16'h1); chk("rereq_addr", 107, 16'(ram_addr), 16'h50);
        chk("rereq_ram_we", 107, 16'(ram_we), 16'h0);
        next_cycle();
        drive(0, 16'h0000, 8'h00, 1, 0, 0, 7'h00, 8'h00);
        @(posedge m2);
        chk("rereq_rvalid", 108, 16'(eng_rvalid), 16'h1); chk("rereq_rdat", 108, 16'(eng_rdat), 16'hD0);
        chk("drained_ram_we", 108, 16'(ram_we), 16'h0);
        next_cycle();

        chk("mem05", 200, 16'(mem[7'h05]), 16'h3C);
        chk("mem06", 200, 16'(mem[7'h06]), 16'h5A);
        chk("mem10", 200, 16'(mem[7'h10]), 16'h99);
        chk("mem20", 200, 16'(mem[7'h20]), 16'h55);
        chk("mem30_untouched", 200, 16'(mem[7'h30]), 16'hB0);
        chk("mem41", 200, 16'(mem[7'h41]), 16'h77);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/snd_n163_arb.md
SND_N163_ARB -- requirements
Module: snd_n163_arb

Interface
REQ-001 SHALL have one clock, m2; all state updates on the falling edge of m2.
REQ-002 SHALL use map_rst as reset: synchronous, active-high, sampled on the falling edge of m2.
REQ-003 Ports, one per line (name  direction  width  meaning):
  m2  in  1  clock, one CPU bus cycle per period
  map_rst  in  1  synchronous active-high reset
  cpu_addr  in  16  CPU address
  cpu_data  in  8  CPU write data
  cpu_rw  in  1  1=read, 0=write
  cpu_dout  out  8  data-port read value
  eng_req  in  1  engine RAM request, held until granted
  eng_we  in  1  engine request is a write
  eng_addr  in  7  engine RAM address
  eng_wdat  in  8  engine write data
  eng_gnt  out  1  one-cycle grant pulse
  eng_rdat  out  8  engine read data
  eng_rvalid  out  1  eng_rdat valid, one-cycle pulse
  ram_addr  out  7  single-port wave RAM address
  ram_we  out  1  wave RAM write enable
  ram_wdat  out  8  wave RAM write data
  ram_rdat  in  8  wave RAM read data, one-cycle latency
  addr_reg  out  7  current CPU address pointer
  auto_inc  out  1  auto-increment flag

Function
REQ-004 Data port SHALL decode as cpu_addr[15:11]==5'b01001 ($4800-$4FFF); address port as cpu_addr[15:11]==5'b11111 ($F800-$FFFF).
REQ-005 Address-port write SHALL load addr_reg<=cpu_data[6:0] and auto_inc<=cpu_data[7], and set prefetch_pending.
REQ-006 Data-port write SHALL push {addr_reg, cpu_data} into a 2-entry write FIFO.
REQ-007 Data-port access (read or write) with auto_inc=1 SHALL increment addr_reg mod 128 (7F->00) after use; any data-port access SHALL set prefetch_pending.
REQ-008 cpu_dout SHALL be the prefetch latch; a read returns the latch value at the pre-increment address.
REQ-009 CPU bus writes SHALL be ignored while map_rst=1.
REQ-010 One RAM slot per cycle; owner chosen among: WR (FIFO head), PF (read addr_reg), ENG, IDLE.
REQ-011 Priority: FIFO full -> WR; else engine starved -> ENG; else FIFO non-empty -> WR; else prefetch_pending -> PF; else eng_req -> ENG; else IDLE.
REQ-012 Engine is starved when eng_req has been high and ungranted for >=3 consecutive cycles.
REQ-013 WR slot: ram_we=1, ram_addr/ram_wdat = FIFO head; head popped the same cycle.
REQ-014 PF slot: ram_addr=addr_reg, ram_we=0, prefetch_pending cleared; latch<=ram_rdat next cycle.
REQ-015 If addr_reg changes or a data-port access occurs during a PF slot, prefetch_pending SHALL remain set.
REQ-016 ENG slot: eng_gnt=1, ram_addr=eng_addr, ram_we=eng_we, ram_wdat=eng_wdat; for reads eng_rvalid=1 next cycle with eng_rdat=ram_rdat.
REQ-017 Engine SHALL drop eng_req or present a new request the cycle after eng_gnt.
REQ-018 A FIFO push and pop in the same cycle SHALL leave the count unchanged; with REQ-011 the count SHALL never exceed 2.
REQ-019 IDLE slot: ram_we=0, ram_addr holds the previous value.

Reset
REQ-020 On map_rst: addr_reg=0, auto_inc=0, FIFO empty, starvation counter=0, prefetch_pending=1, cpu_dout=0, eng_gnt=0, eng_rvalid=0, ram_we=0, ram_addr=0, ram_wdat=0.
REQ-021 Reset mid-operation SHALL discard queued writes and any outstanding engine grant or read; the engine re-requests.
REQ-022 The first slot after reset release with no FIFO entry SHALL be PF at address 0.

Verification
REQ-023 $F800<=0x85, then $4800<=0x3C, 0x5A -> RAM[05]=3C, RAM[06]=5A; addr_reg=07.
REQ-024 $F800<=0xFF, then read $4800 twice -> first read returns RAM[7F], second returns RAM[00]; addr_reg wraps to 01.
REQ-025 eng_req held during back-to-back CPU data writes -> eng_gnt within 4 cycles of the request; FIFO count <=2 throughout.
REQ-026 Engine read of addr 0x40 with an idle CPU -> eng_gnt in the same cycle; eng_rvalid the next cycle with eng_rdat=RAM[40].
REQ-027 Two CPU writes queued and map_rst asserted -> RAM unchanged, FIFO empty, addr_reg=0, PF at address 0 after release.
REQ-028 $F800<=0x10, write 0x99 with auto_inc=0, then read $4800 -> cpu_dout=0x99 (the write commits before the prefetch).
